board_memory: RTL and testbench

BOARD_MEMORY -- requirements
Module: board_memory

---
 rtl/board_memory.sv | 114 +++++++++++
 tb/tb_board_memory.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/board_memory.sv
// board_memory: dual-port board RAM that self-initialises box-id and seven-segment tables
module board_memory #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int BOX_BASE    = 162,
    parameter int LED_BASE    = 150,
    parameter int LOCK_TABLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              wr_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              a_locked;
    logic              a_ok;

    function automatic logic in_rng(input logic [ADDR_W-1:0] p, input int base, input int n);
        return int'(p) >= base && int'(p) < base + n;
    endfunction

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] p);
        int         k;
        logic [7:0] pat;
        k = in_rng(p, BOX_BASE, 81) ? int'(p) - BOX_BASE : int'(p) - LED_BASE;
        case (4'(k))
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hD8;
            4'd8:    pat = 8'h80;
            default: pat = 8'h90;
        endcase
        if (in_rng(p, BOX_BASE, 81))
            return DATA_W'(((k / 9) / 3) * 3 + (k % 9) / 3);
        return in_rng(p, LED_BASE, 10) ? DATA_W'(pat) : '0;
    endfunction

    // state, init pointer and registered outputs; array contents survive reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            ptr_q     <= '0;
            wr_err_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_err_q  <= wr_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // INIT sweeps every address once then hands over; init_req only honoured in READY
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = (ptr_q == '1) ? READY : INIT;
        end else if (init_req) begin
            state_d = INIT;
            ptr_d   = '0;
        end
    end

    // write port steering, table lock, write-first A / read-first B, reads frozen during INIT
    always_comb begin
        ready     = state_q == READY;
        a_locked  = LOCK_TABLES != 0 && (in_rng(a_addr, BOX_BASE, 81) || in_rng(a_addr, LED_BASE, 10));
        a_ok      = ready && !init_req && a_we && !a_locked;
        wr_err_d  = ready && !init_req && a_we && a_locked;
        mem_we    = !ready || a_ok;
        mem_waddr = ready ? a_addr : ptr_q;
        mem_wdata = ready ? a_wdata : init_val(ptr_q);
        a_rdata_d = ready ? (a_ok ? a_wdata : mem_q[a_addr]) : a_rdata_q;
        b_rdata_d = ready ? mem_q[b_addr] : b_rdata_q;
    end

    // single shared write port into the array
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign wr_err  = wr_err_q;
endmodule

// File: tb/tb_board_memory.sv
// tb_board_memory: scoreboard bench for board_memory with directed vectors
module tb_board_memory;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_req = 1'b0;
    logic       a_we = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0;
    logic       ready, wr_err;
    logic [7:0] a_rdata, b_rdata;
    logic [8:0] b_addr9 = '0;
    logic       ready9, wr_err9;
    logic [7:0] a_rdata9, b_rdata9;

    always #5 clk = ~clk;

    board_memory dut (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(ready),
        .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata), .wr_err(wr_err)
    );

    board_memory #(.ADDR_W(9)) dut9 (
        .clk(clk), .rst(rst), .init_req(1'b0), .ready(ready9),
        .a_we(1'b0), .a_addr(9'd0), .a_wdata(8'd0), .a_rdata(a_rdata9),
        .b_addr(b_addr9), .b_rdata(b_rdata9), .wr_err(wr_err9)
    );

    typedef struct {
        int         issue;
        int         kind;
        logic [7:0] exp;
        string      name;
    } ent_t;

    ent_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sel(input int k);
        return k == 0 ? a_rdata : k == 1 ? b_rdata : k == 2 ? {7'd0, wr_err} :
               k == 3 ? {7'd0, ready} : b_rdata9;
    endfunction

    task automatic drive(input logic we, input logic [7:0] aa, input logic [7:0] wd,
                         input logic [7:0] bb, input logic ir);
        @(negedge clk);
        a_we = we; a_addr = aa; a_wdata = wd; b_addr = bb; init_req = ir;
    endtask

    task automatic exp_(input int kind, input logic [7:0] v, input string n);
        sb.push_back('{cyc, kind, v, n});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].issue < cyc) begin
                ent_t e;
                e = sb.pop_front();
                if (e.issue == cyc - 1) check(e.name, sel(e.kind), e.exp);
                else begin
                    total++; bad++;
                    $display("FAIL %s: not sampled in time (issued %0d, now %0d)", e.name, e.issue, cyc);
                end
            end
        end
    end

    initial begin
        int n, n8, n9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_wr_err", wr_err, 0);
        @(negedge clk) rst = 1'b0;
        n = 0; n8 = 0; n9 = 0;
        while ((n8 == 0 || n9 == 0) && n < 1000) begin
            @(posedge clk); #1; n++;
            if (ready && n8 == 0) n8 = n;
            if (ready9 && n9 == 0) n9 = n;
        end
        check("ready_latency", n8, 256);
        check("ready_latency_w9", n9, 512);

        @(negedge clk) b_addr9 = 9'd511; exp_(4, 8'h00, "w9_511");
        @(negedge clk) b_addr9 = 9'd202; exp_(4, 8'h04, "w9_202");
        @(negedge clk) b_addr9 = 9'd159; exp_(4, 8'h90, "w9_159");
        @(negedge clk) b_addr9 = 9'd170; exp_(4, 8'h02, "w9_170");

        drive(0, 202, 0, 151, 0); exp_(0, 8'h04, "a_202"); exp_(1, 8'hF9, "b_151");
        drive(0, 40, 0, 0, 0);    exp_(0, 8'h00, "a_40");  exp_(2, 0, "err_idle");
        drive(1, 12, 8'h07, 12, 0); exp_(0, 8'h07, "a_wf_12"); exp_(1, 8'h00, "b_rf_12"); exp_(2, 0, "err_12");
        drive(0, 0, 0, 12, 0);    exp_(1, 8'h07, "b_12_new");
        drive(1, 159, 8'hFF, 0, 0); exp_(2, 1, "err_159"); exp_(0, 8'h90, "a_159_rej");
        drive(0, 159, 0, 0, 0);   exp_(2, 0, "err_once"); exp_(0, 8'h90, "a_159_kept");
        drive(1, 160, 8'hFF, 0, 0); exp_(2, 0, "err_160"); exp_(0, 8'hFF, "a_160_wr");
        drive(0, 160, 0, 0, 0);   exp_(0, 8'hFF, "a_160_kept");
        drive(1, 170, 8'h55, 170, 0); exp_(2, 1, "err_170"); exp_(0, 8'h02, "a_170_rej"); exp_(1, 8'h02, "b_170");
        drive(0, 170, 0, 0, 0);   exp_(0, 8'h02, "a_170_kept"); exp_(2, 0, "err_170_once");
        drive(1, 162, 8'h33, 0, 0); exp_(2, 1, "err_162"); exp_(0, 8'h00, "a_162_rej");
        drive(1, 150, 8'h33, 0, 0); exp_(2, 1, "err_150"); exp_(0, 8'hC0, "a_150_rej");
        drive(1, 242, 8'h33, 0, 0); exp_(2, 1, "err_242"); exp_(0, 8'h08, "a_242_rej");
        drive(1, 243, 8'h33, 0, 0); exp_(2, 0, "err_243"); exp_(0, 8'h33, "a_243_wr");
        drive(1, 3, 8'h01, 0, 0); exp_(0, 8'h01, "a_3_wr");
        drive(1, 3, 8'hAA, 202, 1);
        exp_(0, 8'h01, "a_ireq_drop"); exp_(1, 8'h04, "b_ireq"); exp_(2, 0, "err_ireq"); exp_(3, 0, "ready_fall");

        n = 1;
        while (n < 1000) begin
            @(negedge clk);
            a_we = (n == 100); init_req = (n == 100); a_addr = 8'd3; a_wdata = 8'hEE;
            @(posedge clk); #1;
            if (n == 100) begin
                check("hold_a_init", a_rdata, 8'h01);
                check("hold_b_init", b_rdata, 8'h04);
            end
            if (ready) break;
            n++;
        end
        check("init_req_low", n, 256);
        drive(0, 3, 0, 12, 0);  exp_(0, 8'h00, "a_3_reinit"); exp_(1, 8'h00, "b_12_reinit");
        drive(0, 159, 0, 243, 0); exp_(0, 8'h90, "a_159_reinit"); exp_(1, 8'h00, "b_243_reinit");

        drive(0, 151, 0, 202, 1); exp_(0, 8'hF9, "a_151"); exp_(1, 8'h04, "b_202"); exp_(3, 0, "ready_fall2");
        n = 1;
        while (n < 50) begin
            drive(0, 0, 0, 0, 0);
            @(posedge clk); #1; n++;
        end
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_mid_a", a_rdata, 0);
        check("rst_mid_b", b_rdata, 0);
        check("rst_mid_ready", ready, 0);
        check("rst_mid_err", wr_err, 0);
        @(negedge clk) rst = 1'b0;
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("rst_mid_latency", n, 256);
        drive(0, 202, 0, 12, 0); exp_(0, 8'h04, "a_202_rst"); exp_(1, 8'h00, "b_12_rst");
        repeat (3) drive(0, 0, 0, 0, 0);
        @(posedge clk); #2;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
